knn_vote: RTL and testbench
===========================

KNN_VOTE -- requirements
Module: knn_vote

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of distance inputs.
REQ-002 SHALL have parameter NBR_LABELS, default 4, number of valid class labels (0..NBR_LABELS-1).
REQ-003 SHALL have parameter NBR_KNN, default 4, number of neighbour labels voted per test point.
REQ-004 SHALL have parameter LABEL_BITS, default 8, label width.
REQ-005 SHALL have port clk  input  1  the block's one clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port en  input  1  global enable; low freezes all state.
REQ-008 SHALL have port start  input  1  begin new vote; sampled in IDLE only.
REQ-009 SHALL have port lbl_valid  input  1  lbl_in/dist_in carry one neighbour.
REQ-010 SHALL have port lbl_in  input  LABEL_BITS  neighbour label.
REQ-011 SHALL have port dist_in  input  DATA_W  neighbour distance, from the knn_list chain output.
REQ-012 SHALL have port ready  output  1  high in COLLECT; transfer = lbl_valid & ready & en.
REQ-013 SHALL have port done  output  1  one-cycle pulse when winner valid.
REQ-014 SHALL have port winner  output  LABEL_BITS  winning label, held until next start.
REQ-015 SHALL have port winner_votes  output  8  vote count of winner, held.
REQ-016 SHALL have port err  output  1  sticky: out-of-range label seen in current vote.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT, SCAN, DONE; all transitions only on cycles with en=1.
REQ-018 IDLE: start=1 SHALL clear all per-label vote counters, accepted-count and err, and go to COLLECT next cycle.
REQ-019 COLLECT: each transfer SHALL increment the counter of lbl_in and the accepted-count, saturating counters at NBR_KNN.
REQ-020 A transfer with lbl_in >= NBR_LABELS SHALL increment accepted-count only and set err.
REQ-021 After the NBR_KNN-th transfer the FSM SHALL go to SCAN next cycle; ready SHALL drop that same next cycle.
REQ-022 SCAN SHALL examine one label index per cycle, 0 to NBR_LABELS-1 (NBR_LABELS cycles), keeping the running maximum.
REQ-023 A label replaces the running maximum only if its count is strictly greater (tie: lower index wins, unless REQ-034).
REQ-024 After the last index the FSM SHALL enter DONE, load winner/winner_votes, assert done for exactly one cycle, then return to IDLE.
REQ-025 Latency from last transfer to done SHALL be NBR_LABELS+1 cycles (en held high).
REQ-026 If no valid label received (all out of range) winner SHALL be 0 and winner_votes 0.
REQ-027 start outside IDLE SHALL be ignored; lbl_valid outside COLLECT SHALL be ignored.
REQ-028 en=0 SHALL hold state, counters and outputs; done held high across en=0 SHALL remain one enabled cycle long.
REQ-029 Vote counters SHALL be $clog2(NBR_KNN+1) bits; winner_votes zero-extended to 8 bits.

Reset
REQ-030 rst=1 SHALL asynchronously force state IDLE, ready=0, done=0, winner=0, winner_votes=0, err=0, all counters 0.
REQ-031 rst asserted mid-COLLECT or mid-SCAN SHALL abort the vote; no done pulse follows release.
REQ-032 After rst release the block SHALL accept start on the first clk edge with en=1.

Configuration
REQ-033 Macro KNN_VOTE_DIST_TIEBRK_EN SHALL be the only compile option.
REQ-034 With it defined: per-label minimum dist_in registers (DATA_W, reset/start to all-ones) SHALL be kept; on equal counts the label with strictly smaller minimum distance wins, then lower index.
REQ-035 Without it: no distance registers; dist_in unused; tie rule of REQ-023 only.

Verification
REQ-036 Labels 2,2,1,3 after start -> done NBR_LABELS+1=5 cycles after last transfer, winner=2, winner_votes=2, err=0.
REQ-037 Labels 1,3,3,1 dists 5,4,9,8 -> macro off: winner=1; macro on: winner=3 (min dist 4 < 5), votes=2.
REQ-038 Labels 0,7,7,0 -> err=1, winner=0, winner_votes=2; labels 9,9,9,9 -> winner=0, votes=0, err=1.
REQ-039 rst pulsed after two transfers -> ready=0, outputs 0 immediately; no done; new vote 3,3,3,3 -> winner=3, votes=4.
REQ-040 en low 3 cycles mid-SCAN and start pulsed during COLLECT -> result unchanged, latency extended by 3, single done pulse.

Source files
------------

// File: rtl/knn_vote.sv
// rtl/knn_vote.sv - majority vote over the K nearest-neighbour labels
//
// Purpose: collects NBR_KNN (label, distance) pairs after a start, counts
// votes per label, then scans the per-label counters one index per cycle
// and reports the label with the most votes.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                global enable, low freezes all state
//   start             begin a new vote (IDLE only)
//   lbl_valid, lbl_in, dist_in   neighbour input, accepted while ready
//   ready             high in COLLECT
//   done              one-cycle result strobe
//   winner, winner_votes         result, held until the next result
//   err               sticky out-of-range label flag for the current vote
// Compile option: KNN_VOTE_DIST_TIEBRK_EN - break equal vote counts by the
// smallest neighbour distance seen for each label.

module knn_vote #(
    parameter int DATA_W     = 32,
    parameter int NBR_LABELS = 4,
    parameter int NBR_KNN    = 4,
    parameter int LABEL_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic                  lbl_valid,
    input  logic [LABEL_BITS-1:0] lbl_in,
    input  logic [DATA_W-1:0]     dist_in,
    output logic                  ready,
    output logic                  done,
    output logic [LABEL_BITS-1:0] winner,
    output logic [7:0]            winner_votes,
    output logic                  err
);

    localparam int CW = $clog2(NBR_KNN + 1);
    localparam int IW = (NBR_LABELS > 1) ? $clog2(NBR_LABELS) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, SCAN, DONE} state_t;

    state_t          state;
    state_t          state_nx;

    logic [CW-1:0]   cnt [NBR_LABELS];
    logic [CW-1:0]   acc;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   best_idx;
    logic [CW-1:0]   best_cnt;
    logic [CW-1:0]   cur_cnt;
    logic [CW-1:0]   cand_cnt;
    logic [IW-1:0]   cand_idx;
    logic            take;
    logic            xfer;
    logic            last_xfer;
    logic            scan_last;
    logic            in_range;

`ifdef KNN_VOTE_DIST_TIEBRK_EN
    logic [DATA_W-1:0] dmin [NBR_LABELS];
    logic [DATA_W-1:0] best_d;
    logic [DATA_W-1:0] cur_d;
`else
    logic unused_dist;
    assign unused_dist = ^dist_in;
`endif

    assign ready     = (state == COLLECT);
    assign done      = (state == DONE);
    assign xfer      = ready && lbl_valid && en;
    assign last_xfer = xfer && (acc == CW'(NBR_KNN - 1));
    assign scan_last = (idx == IW'(NBR_LABELS - 1));
    assign in_range  = (lbl_in < LABEL_BITS'(NBR_LABELS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (en) begin
            case (state)
                IDLE:    if (start) state_nx = COLLECT;
                COLLECT: if (last_xfer) state_nx = SCAN;
                SCAN:    if (scan_last) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Counter at the current scan index.
    always_comb begin
        cur_cnt = '0;
`ifdef KNN_VOTE_DIST_TIEBRK_EN
        cur_d = '1;
`endif
        for (int i = 0; i < NBR_LABELS; i++) begin
            if (idx == IW'(i)) begin
                cur_cnt = cnt[i];
`ifdef KNN_VOTE_DIST_TIEBRK_EN
                cur_d = dmin[i];
`endif
            end
        end
    end

    // Strictly-greater replacement keeps the lower index on ties; the
    // optional rule lets a strictly closer neighbour win an equal count.
    always_comb begin
`ifdef KNN_VOTE_DIST_TIEBRK_EN
        take = (cur_cnt > best_cnt) ||
               ((cur_cnt == best_cnt) && (cur_d < best_d));
`else
        take = (cur_cnt > best_cnt);
`endif
        cand_cnt = take ? cur_cnt : best_cnt;
        cand_idx = take ? idx : best_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBR_LABELS; i++) begin
                cnt[i] <= '0;
`ifdef KNN_VOTE_DIST_TIEBRK_EN
                dmin[i] <= '1;
`endif
            end
`ifdef KNN_VOTE_DIST_TIEBRK_EN
            best_d <= '1;
`endif
            acc          <= '0;
            idx          <= '0;
            best_idx     <= '0;
            best_cnt     <= '0;
            winner       <= '0;
            winner_votes <= '0;
            err          <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NBR_LABELS; i++) begin
                            cnt[i] <= '0;
`ifdef KNN_VOTE_DIST_TIEBRK_EN
                            dmin[i] <= '1;
`endif
                        end
                        acc <= '0;
                        err <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (lbl_valid) begin
                        if (acc != CW'(NBR_KNN)) acc <= acc + 1'b1;
                        if (!in_range) err <= 1'b1;
                        for (int i = 0; i < NBR_LABELS; i++) begin
                            if (lbl_in == LABEL_BITS'(i)) begin
                                if (cnt[i] != CW'(NBR_KNN)) cnt[i] <= cnt[i] + 1'b1;
`ifdef KNN_VOTE_DIST_TIEBRK_EN
                                if (dist_in < dmin[i]) dmin[i] <= dist_in;
`endif
                            end
                        end
                        if (last_xfer) begin
                            idx      <= '0;
                            best_idx <= '0;
                            best_cnt <= '0;
`ifdef KNN_VOTE_DIST_TIEBRK_EN
                            best_d   <= '1;
`endif
                        end
                    end
                end
                SCAN: begin
                    best_cnt <= cand_cnt;
                    best_idx <= cand_idx;
`ifdef KNN_VOTE_DIST_TIEBRK_EN
                    best_d   <= take ? cur_d : best_d;
`endif
                    idx <= idx + 1'b1;
                    if (scan_last) begin
                        winner       <= LABEL_BITS'(cand_idx);
                        winner_votes <= 8'(cand_cnt);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// tb/tb_knn_vote.sv - directed self-checking bench for knn_vote

module tb_knn_vote;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic        lbl_valid;
    logic [7:0]  lbl_in;
    logic [31:0] dist_in;
    logic        ready;
    logic        done;
    logic [7:0]  winner;
    logic [7:0]  winner_votes;
    logic        err;

    int total = 0;
    int bad   = 0;
    int lat;
    int ndone;

    always #5 clk = ~clk;

    knn_vote dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .start        (start),
        .lbl_valid    (lbl_valid),
        .lbl_in       (lbl_in),
        .dist_in      (dist_in),
        .ready        (ready),
        .done         (done),
        .winner       (winner),
        .winner_votes (winner_votes),
        .err          (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] l, input logic [31:0] d);
        lbl_valid = 1'b1;
        lbl_in    = l;
        dist_in   = d;
        tick();
        lbl_valid = 1'b0;
    endtask

    // Three transfers, then the last one; lat counts clock edges from the
    // cycle the last transfer is presented until done is seen.
    // junk: keep lbl_valid high with label 1 during SCAN (must be ignored).
    // gap:  pulse start during COLLECT and drop en for 3 cycles mid-SCAN.
    task automatic vote(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d,
                        input logic [31:0] da, input logic [31:0] db,
                        input logic [31:0] dc, input logic [31:0] dd,
                        input bit junk, input bit gap, output int l);
        send(a, da);
        send(b, db);
        if (gap) start = 1'b1;
        send(c, dc);
        start     = 1'b0;
        lbl_valid = 1'b1;
        lbl_in    = d;
        dist_in   = dd;
        l = 0;
        while (l < 40) begin
            tick();
            l++;
            if (junk) lbl_in = 8'd1;
            else lbl_valid = 1'b0;
            if (done) break;
            if (gap && l == 2) en = 1'b0;
            if (gap && l == 5) en = 1'b1;
        end
        lbl_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; lbl_valid = 1'b0;
        lbl_in = '0; dist_in = '0;
        tick();
        tick();
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_winner", winner, 0);
        chk("rst_votes", winner_votes, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // Start on the first enabled edge after release.
        do_start();
        chk("start_ready", ready, 1);
        vote(8'd2, 8'd2, 8'd1, 8'd3, 0, 0, 0, 0, 1'b1, 1'b0, lat);
        chk("v1_lat", lat, 5);
        chk("v1_done", done, 1);
        chk("v1_ready", ready, 0);
        chk("v1_winner", winner, 2);
        chk("v1_votes", winner_votes, 2);
        chk("v1_err", err, 0);
        tick();
        chk("v1_done_pulse", done, 0);

        do_start();
        vote(8'd1, 8'd3, 8'd3, 8'd1, 5, 4, 9, 8, 1'b0, 1'b0, lat);
        chk("v2_lat", lat, 5);
`ifdef KNN_VOTE_DIST_TIEBRK_EN
        chk("v2_winner", winner, 3);
`else
        chk("v2_winner", winner, 1);
`endif
        chk("v2_votes", winner_votes, 2);
        tick();

        do_start();
        vote(8'd0, 8'd7, 8'd7, 8'd0, 1, 1, 1, 1, 1'b0, 1'b0, lat);
        chk("v3_lat", lat, 5);
        chk("v3_err", err, 1);
        chk("v3_winner", winner, 0);
        chk("v3_votes", winner_votes, 2);
        // done frozen while en is low, then ends after one enabled cycle.
        en = 1'b0;
        tick();
        tick();
        chk("v3_done_hold", done, 1);
        en = 1'b1;
        tick();
        chk("v3_done_end", done, 0);

        do_start();
        chk("v4_err_clear", err, 0);
        vote(8'd9, 8'd9, 8'd9, 8'd9, 0, 0, 0, 0, 1'b0, 1'b0, lat);
        chk("v4_lat", lat, 5);
        chk("v4_winner", winner, 0);
        chk("v4_votes", winner_votes, 0);
        chk("v4_err", err, 1);
        tick();

        do_start();
        vote(8'd1, 8'd1, 8'd2, 8'd0, 0, 0, 0, 0, 1'b0, 1'b1, lat);
        chk("v5_lat", lat, 8);
        chk("v5_winner", winner, 1);
        chk("v5_votes", winner_votes, 2);
        chk("v5_err", err, 0);
        tick();
        chk("v5_done_pulse", done, 0);

        // Reset in the middle of COLLECT aborts the vote.
        do_start();
        send(8'd2, 0);
        send(8'd5, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_winner", winner, 0);
        chk("mid_rst_votes", winner_votes, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_done", done, 0);
        tick();
        rst = 1'b0;
        ndone = 0;
        lbl_valid = 1'b1;
        lbl_in = 8'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) ndone++;
        end
        lbl_valid = 1'b0;
        chk("post_rst_no_done", ndone, 0);
        chk("post_rst_ready", ready, 0);

        do_start();
        vote(8'd3, 8'd3, 8'd3, 8'd3, 0, 0, 0, 0, 1'b0, 1'b0, lat);
        chk("v6_lat", lat, 5);
        chk("v6_winner", winner, 3);
        chk("v6_votes", winner_votes, 4);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
